// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency results
// queue in a small FIFO, and a pending-register scoreboard drives decode stall flags.
module wb_arbiter #(
    parameter int LATE_DEPTH = 2,
    parameter int REG_NUM    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wb_valid,
    input  logic [4:0]                    wb_regid,
    input  logic [31:0]                   wb_data,
    input  logic                          late_valid,
    output logic                          late_ready,
    input  logic [4:0]                    late_regid,
    input  logic [31:0]                   late_data,
    input  logic                          issue_valid,
    input  logic [4:0]                    issue_regid,
    output logic                          issue_ready,
    input  logic [4:0]                    rs1_regid,
    output logic                          rs1_busy,
    input  logic [4:0]                    rs2_regid,
    output logic                          rs2_busy,
    output logic                          reg_write,
    output logic [4:0]                    reg_regid,
    output logic [31:0]                   reg_writedata,
    output logic [$clog2(LATE_DEPTH):0]   late_count
);

    localparam int PTR_W = $clog2(LATE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_COUNT = CNT_W'(LATE_DEPTH);

    localparam logic [1:0] SRC_NONE   = 2'd0;
    localparam logic [1:0] SRC_PIPE   = 2'd1;
    localparam logic [1:0] SRC_FIFO   = 2'd2;
    localparam logic [1:0] SRC_BYPASS = 2'd3;

    logic [4:0]         fifo_regid [LATE_DEPTH];
    logic [31:0]        fifo_data  [LATE_DEPTH];
    logic [PTR_W-1:0]   head_ptr;
    logic [PTR_W-1:0]   tail_ptr;
    logic [CNT_W-1:0]   count;
    logic [REG_NUM-1:0] pending;

    logic        fifo_empty;
    logic        fifo_full;
    logic        wb_take;
    logic        late_fire;
    logic        pop;
    logic        push;
    logic        late_write;
    logic        issue_set;
    logic [1:0]  src;
    logic [4:0]  sel_regid;
    logic [31:0] sel_data;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_COUNT);
    assign late_ready = ~rst & ~fifo_full;
    assign late_fire  = late_valid & late_ready;
    assign wb_take    = wb_valid & (wb_regid != 5'd0);

    // Older queued results always beat a new arrival, which keeps late results in order.
    always_comb begin
        src = SRC_NONE;
        if (!rst) begin
            if (wb_take) begin
                src = SRC_PIPE;
            end else if (!fifo_empty) begin
                src = SRC_FIFO;
            end else if (late_fire) begin
                src = SRC_BYPASS;
            end
        end
    end

    assign pop  = (src == SRC_FIFO);
    assign push = late_fire & (src != SRC_BYPASS);

    always_comb begin
        sel_regid = '0;
        sel_data  = '0;
        case (src)
            SRC_PIPE: begin
                sel_regid = wb_regid;
                sel_data  = wb_data;
            end
            SRC_FIFO: begin
                sel_regid = fifo_regid[head_ptr];
                sel_data  = fifo_data[head_ptr];
            end
            SRC_BYPASS: begin
                sel_regid = late_regid;
                sel_data  = late_data;
            end
            default: ;
        endcase
    end

    // A late result aimed at r0 still consumes its slot but never reaches the regfile.
    assign reg_write     = (sel_regid != 5'd0);
    assign reg_regid     = sel_regid;
    assign reg_writedata = reg_write ? sel_data : 32'd0;
    assign late_count    = count;

    assign late_write = reg_write & ((src == SRC_FIFO) | (src == SRC_BYPASS));
    assign issue_set  = issue_valid & issue_ready & (issue_regid != 5'd0);

    assign issue_ready = ~rst & ~pending[issue_regid];
    assign rs1_busy    = pending[rs1_regid] & ~(late_write & (sel_regid == rs1_regid));
    assign rs2_busy    = pending[rs2_regid] & ~(late_write & (sel_regid == rs2_regid));

    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                tail_ptr <= tail_ptr + 1'b1;
            end
            if (pop) begin
                head_ptr <= head_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_regid[tail_ptr] <= late_regid;
            fifo_data[tail_ptr]  <= late_data;
        end
    end

    // The set is written last so a same-cycle set and clear of one register leaves it pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            if (late_write) begin
                pending[sel_regid] <= 1'b0;
            end
            if (issue_set) begin
                pending[issue_regid] <= 1'b1;
            end
        end
    end

    wb_to_pending_reg: assert property (@(posedge clk) disable iff (rst)
        !(wb_take && pending[wb_regid]));

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: a reference queue of accepted late results predicts every write-port
// cycle, while per-feature tasks check ready, occupancy and busy flags inline.
module tb_wb_arbiter;

    localparam int LATE_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_regid;
    logic [31:0] wb_data;
    logic        late_valid;
    logic        late_ready;
    logic [4:0]  late_regid;
    logic [31:0] late_data;
    logic        issue_valid;
    logic [4:0]  issue_regid;
    logic        issue_ready;
    logic [4:0]  rs1_regid;
    logic        rs1_busy;
    logic [4:0]  rs2_regid;
    logic        rs2_busy;
    logic        reg_write;
    logic [4:0]  reg_regid;
    logic [31:0] reg_writedata;
    logic [1:0]  late_count;

    typedef struct packed {
        logic [4:0]  regid;
        logic [31:0] data;
    } late_item_t;

    late_item_t late_q[$];
    int checks_total  = 0;
    int checks_passed = 0;

    logic        sb_we;
    logic [4:0]  sb_regid;
    logic [31:0] sb_data;
    logic        sb_bypassed;
    logic        sb_full;
    late_item_t  sb_item;

    wb_arbiter #(.LATE_DEPTH(LATE_DEPTH), .REG_NUM(32)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_regid(wb_regid), .wb_data(wb_data),
        .late_valid(late_valid), .late_ready(late_ready),
        .late_regid(late_regid), .late_data(late_data),
        .issue_valid(issue_valid), .issue_regid(issue_regid), .issue_ready(issue_ready),
        .rs1_regid(rs1_regid), .rs1_busy(rs1_busy),
        .rs2_regid(rs2_regid), .rs2_busy(rs2_busy),
        .reg_write(reg_write), .reg_regid(reg_regid), .reg_writedata(reg_writedata),
        .late_count(late_count)
    );

    always #5 clk = ~clk;

    // Predict the write port from the queue of accepted results, then pop/push it like the FIFO would.
    always @(negedge clk) begin
        sb_we       = 1'b0;
        sb_regid    = '0;
        sb_data     = '0;
        sb_bypassed = 1'b0;
        if (rst) begin
            late_q.delete();
        end else begin
            sb_full = (late_q.size() >= LATE_DEPTH);
            if (wb_valid && wb_regid != 5'd0) begin
                sb_we    = 1'b1;
                sb_regid = wb_regid;
                sb_data  = wb_data;
            end else if (late_q.size() > 0) begin
                sb_item = late_q.pop_front();
                if (sb_item.regid != 5'd0) begin
                    sb_we    = 1'b1;
                    sb_regid = sb_item.regid;
                    sb_data  = sb_item.data;
                end
            end else if (late_valid && !sb_full) begin
                sb_bypassed = 1'b1;
                if (late_regid != 5'd0) begin
                    sb_we    = 1'b1;
                    sb_regid = late_regid;
                    sb_data  = late_data;
                end
            end
            if (late_valid && !sb_full && !sb_bypassed) begin
                late_q.push_back('{regid: late_regid, data: late_data});
            end
        end
        checks_total++;
        if ({reg_write, reg_regid, reg_writedata} !== {sb_we, sb_regid, sb_data})
            $display("[TB] FAIL write_port @%0t: got we=%0b reg=%0d data=%h, expected we=%0b reg=%0d data=%h",
                     $time, reg_write, reg_regid, reg_writedata, sb_we, sb_regid, sb_data);
        else
            checks_passed++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        wb_valid    = 1'b0;
        wb_regid    = '0;
        wb_data     = '0;
        late_valid  = 1'b0;
        late_regid  = '0;
        late_data   = '0;
        issue_valid = 1'b0;
        issue_regid = '0;
        rs1_regid   = '0;
        rs2_regid   = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        tick();
        tick();
        #2;
        checks_total++;
        if (late_count !== 2'd0) $display("[TB] FAIL reset_count: got %0d expected 0", late_count);
        else checks_passed++;
        checks_total++;
        if (late_ready !== 1'b0) $display("[TB] FAIL reset_late_ready: got %0b expected 0", late_ready);
        else checks_passed++;
        checks_total++;
        if (issue_ready !== 1'b0) $display("[TB] FAIL reset_issue_ready: got %0b expected 0", issue_ready);
        else checks_passed++;
        tick();
        rst       = 1'b0;
        rs1_regid = 5'd4;
        #2;
        checks_total++;
        if (late_ready !== 1'b1) $display("[TB] FAIL post_reset_late_ready: got %0b expected 1", late_ready);
        else checks_passed++;
        checks_total++;
        if (issue_ready !== 1'b1) $display("[TB] FAIL post_reset_issue_ready: got %0b expected 1", issue_ready);
        else checks_passed++;
        checks_total++;
        if (rs1_busy !== 1'b0) $display("[TB] FAIL post_reset_busy: got %0b expected 0", rs1_busy);
        else checks_passed++;
        tick();
    endtask

    task automatic test_bypass();
        set_idle();
        late_valid = 1'b1;
        late_regid = 5'd5;
        late_data  = 32'hA5;
        #2;
        checks_total++;
        if ({reg_write, reg_regid, reg_writedata} !== {1'b1, 5'd5, 32'hA5})
            $display("[TB] FAIL bypass_write: got we=%0b reg=%0d data=%h expected we=1 reg=5 data=a5",
                     reg_write, reg_regid, reg_writedata);
        else checks_passed++;
        tick();
        set_idle();
        #2;
        checks_total++;
        if (late_count !== 2'd0) $display("[TB] FAIL bypass_count: got %0d expected 0", late_count);
        else checks_passed++;
        tick();
    endtask

    task automatic test_priority();
        logic [4:0]  lreg [3] = '{5'd7, 5'd8, 5'd9};
        logic [31:0] ldat [3] = '{32'h70, 32'h80, 32'h90};
        logic [1:0]  cnt_exp [3] = '{2'd0, 2'd1, 2'd2};
        logic        rdy_exp [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            set_idle();
            wb_valid   = 1'b1;
            wb_regid   = 5'd3;
            wb_data    = 32'h30 + 32'(i);
            late_valid = 1'b1;
            late_regid = lreg[i];
            late_data  = ldat[i];
            #2;
            checks_total++;
            if (late_count !== cnt_exp[i]) $display("[TB] FAIL prio_count_%0d: got %0d expected %0d", i, late_count, cnt_exp[i]);
            else checks_passed++;
            checks_total++;
            if (late_ready !== rdy_exp[i]) $display("[TB] FAIL prio_ready_%0d: got %0b expected %0b", i, late_ready, rdy_exp[i]);
            else checks_passed++;
            tick();
        end
        wb_valid = 1'b0;
        #2;
        checks_total++;
        if ({late_count, late_ready, reg_regid} !== {2'd2, 1'b0, 5'd7})
            $display("[TB] FAIL full_pop: got count=%0d ready=%0b reg=%0d expected count=2 ready=0 reg=7",
                     late_count, late_ready, reg_regid);
        else checks_passed++;
        tick();
        #2;
        checks_total++;
        if ({late_count, late_ready, reg_regid} !== {2'd1, 1'b1, 5'd8})
            $display("[TB] FAIL push_pop: got count=%0d ready=%0b reg=%0d expected count=1 ready=1 reg=8",
                     late_count, late_ready, reg_regid);
        else checks_passed++;
        tick();
        set_idle();
        #2;
        checks_total++;
        if ({late_count, reg_regid} !== {2'd1, 5'd9})
            $display("[TB] FAIL net_zero: got count=%0d reg=%0d expected count=1 reg=9", late_count, reg_regid);
        else checks_passed++;
        tick();
        #2;
        checks_total++;
        if ({late_count, reg_write} !== {2'd0, 1'b0})
            $display("[TB] FAIL drained: got count=%0d we=%0b expected count=0 we=0", late_count, reg_write);
        else checks_passed++;
        tick();
    endtask

    task automatic test_scoreboard();
        set_idle();
        issue_valid = 1'b1;
        issue_regid = 5'd9;
        #2;
        checks_total++;
        if (issue_ready !== 1'b1) $display("[TB] FAIL issue9_ready: got %0b expected 1", issue_ready);
        else checks_passed++;
        tick();
        issue_valid = 1'b0;
        rs1_regid   = 5'd9;
        #2;
        checks_total++;
        if ({rs1_busy, rs2_busy, issue_ready} !== 3'b100)
            $display("[TB] FAIL pend9: got rs1=%0b rs2=%0b ready=%0b expected rs1=1 rs2=0 ready=0", rs1_busy, rs2_busy, issue_ready);
        else checks_passed++;
        tick();
        late_valid = 1'b1;
        late_regid = 5'd9;
        late_data  = 32'h99;
        rs2_regid  = 5'd9;
        #2;
        checks_total++;
        if ({rs1_busy, rs2_busy, issue_ready} !== 3'b000)
            $display("[TB] FAIL clear9_same_cycle: got rs1=%0b rs2=%0b ready=%0b expected 0 0 0", rs1_busy, rs2_busy, issue_ready);
        else checks_passed++;
        tick();
        late_valid = 1'b0;
        #2;
        checks_total++;
        if ({rs1_busy, issue_ready} !== 2'b01)
            $display("[TB] FAIL clear9_next: got rs1=%0b ready=%0b expected rs1=0 ready=1", rs1_busy, issue_ready);
        else checks_passed++;
        tick();
        set_idle();
        late_valid  = 1'b1;
        late_regid  = 5'd11;
        late_data   = 32'h11;
        issue_valid = 1'b1;
        issue_regid = 5'd11;
        rs1_regid   = 5'd11;
        #2;
        checks_total++;
        if (issue_ready !== 1'b1) $display("[TB] FAIL issue11_ready: got %0b expected 1", issue_ready);
        else checks_passed++;
        tick();
        late_valid  = 1'b0;
        issue_valid = 1'b0;
        #2;
        checks_total++;
        if ({rs1_busy, issue_ready} !== 2'b10)
            $display("[TB] FAIL set_wins: got rs1=%0b ready=%0b expected rs1=1 ready=0", rs1_busy, issue_ready);
        else checks_passed++;
        tick();
        late_valid = 1'b1;
        late_data  = 32'h12;
        tick();
        late_valid = 1'b0;
        #2;
        checks_total++;
        if ({rs1_busy, issue_ready} !== 2'b01)
            $display("[TB] FAIL clear11: got rs1=%0b ready=%0b expected rs1=0 ready=1", rs1_busy, issue_ready);
        else checks_passed++;
        tick();
    endtask

    task automatic test_regid_zero();
        set_idle();
        late_valid = 1'b1;
        late_regid = 5'd0;
        late_data  = 32'hDEAD;
        #2;
        checks_total++;
        if ({late_ready, reg_write} !== 2'b10)
            $display("[TB] FAIL zero_bypass: got ready=%0b we=%0b expected ready=1 we=0", late_ready, reg_write);
        else checks_passed++;
        tick();
        wb_valid  = 1'b1;
        wb_regid  = 5'd3;
        wb_data   = 32'h33;
        late_data = 32'hBEEF;
        #2;
        checks_total++;
        if (late_count !== 2'd0) $display("[TB] FAIL zero_bypass_count: got %0d expected 0", late_count);
        else checks_passed++;
        tick();
        set_idle();
        #2;
        checks_total++;
        if ({late_count, reg_write} !== {2'd1, 1'b0})
            $display("[TB] FAIL zero_pop: got count=%0d we=%0b expected count=1 we=0", late_count, reg_write);
        else checks_passed++;
        tick();
        issue_valid = 1'b1;
        issue_regid = 5'd0;
        #2;
        checks_total++;
        if ({late_count, issue_ready} !== {2'd0, 1'b1})
            $display("[TB] FAIL zero_issue: got count=%0d ready=%0b expected count=0 ready=1", late_count, issue_ready);
        else checks_passed++;
        tick();
        issue_valid = 1'b0;
        for (int r = 0; r < 16; r++) begin
            rs1_regid = 5'(2 * r);
            rs2_regid = 5'(2 * r + 1);
            #2;
            checks_total++;
            if ({rs1_busy, rs2_busy} !== 2'b00)
                $display("[TB] FAIL zero_sb_%0d: got rs1=%0b rs2=%0b expected 0 0", r, rs1_busy, rs2_busy);
            else checks_passed++;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        set_idle();
        wb_valid    = 1'b1;
        wb_regid    = 5'd3;
        wb_data     = 32'h1;
        late_valid  = 1'b1;
        late_regid  = 5'd12;
        late_data   = 32'hC0;
        issue_valid = 1'b1;
        issue_regid = 5'd4;
        tick();
        wb_data     = 32'h2;
        late_regid  = 5'd13;
        late_data   = 32'hD0;
        issue_regid = 5'd6;
        tick();
        set_idle();
        rst = 1'b1;
        #2;
        checks_total++;
        if ({late_count, reg_write} !== {2'd2, 1'b0})
            $display("[TB] FAIL rst_mid_hold: got count=%0d we=%0b expected count=2 we=0", late_count, reg_write);
        else checks_passed++;
        tick();
        rst       = 1'b0;
        rs1_regid = 5'd4;
        rs2_regid = 5'd6;
        issue_regid = 5'd4;
        #2;
        checks_total++;
        if ({late_count, rs1_busy, rs2_busy, reg_write, issue_ready} !== {2'd0, 4'b0001})
            $display("[TB] FAIL rst_mid_after: got count=%0d rs1=%0b rs2=%0b we=%0b ready=%0b expected 0 0 0 0 1",
                     late_count, rs1_busy, rs2_busy, reg_write, issue_ready);
        else checks_passed++;
        tick();
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            set_idle();
            wb_valid   = ($urandom_range(0, 2) == 0);
            wb_regid   = 5'($urandom_range(1, 31));
            wb_data    = $urandom;
            late_valid = 1'($urandom_range(0, 1));
            late_regid = 5'($urandom_range(0, 31));
            late_data  = $urandom;
            #2;
            checks_total++;
            if ({late_count, late_ready} !== {2'(late_q.size()), (late_q.size() < LATE_DEPTH)})
                $display("[TB] FAIL rand_occupancy_%0d: got count=%0d ready=%0b expected count=%0d ready=%0b",
                         n, late_count, late_ready, late_q.size(), (late_q.size() < LATE_DEPTH));
            else checks_passed++;
            tick();
        end
        set_idle();
        repeat (LATE_DEPTH + 1) tick();
        #2;
        checks_total++;
        if (late_count !== 2'd0) $display("[TB] FAIL rand_drain: got %0d expected 0", late_count);
        else checks_passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_priority();
        test_scoreboard();
        test_regid_zero();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
